sdram_reader: RTL and testbench

SDRAM_READER -- requirements
Module: sdram_reader

---
 rtl/sdram_reader.sv | 155 +++++++++++++++
 tb/tb_sdram_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_reader.sv
// rtl/sdram_reader.sv - Avalon-MM ring-buffer readback engine with credit-limited output FIFO.
// Optional SDRAM_READER_ERR_EN adds a sticky err flag for nonzero readdata[63:32].
module sdram_reader #(
  parameter int unsigned RBUF_SIZE  = 20000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] start_index,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SDRAM_READER_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [31:0] index;
  logic [15:0] remaining;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [15:0]   rem_nxt;
  logic [31:0]   idx_adv;
  logic          credit;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

  // Credit looks at post-update occupancy so a read accepted this cycle already counts.
  always_comb begin
    accept  = read & ~waitrequest;
    push    = readdatavalid & (state != S_IDLE);
    pop     = out_valid & out_ready;
    out_nxt = outstanding + CW'(accept) - CW'(push);
    cnt_nxt = count + CW'(push) - CW'(pop);
    rem_nxt = remaining - 16'(accept);
    idx_adv = (index >= RBUF_SIZE) ? 32'd0 : index + 32'd2;
    credit  = (({1'b0, out_nxt} + {1'b0, cnt_nxt}) < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= readdata[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      base_q      <= 32'd0;
      index       <= 32'd0;
      remaining   <= 16'd0;
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      address     <= 32'd0;
      read        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= out_nxt;
      count       <= cnt_nxt;
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            index     <= start_index;
            remaining <= word_count;
            if (word_count == 16'd0) begin
              done <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              busy    <= 1'b1;
              address <= base_addr + start_index;
              read    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          remaining <= rem_nxt;
          if (accept) begin
            index   <= idx_adv;
            address <= base_q + idx_adv;
          end
          read <= (rem_nxt != 16'd0) && credit;
          if (rem_nxt == 16'd0) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          read <= 1'b0;
          if (outstanding == '0 && count == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_READER_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (push && readdata[63:32] != 32'd0) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^readdata[63:32];
`endif

endmodule

// File: tb/tb_sdram_reader.sv
// tb/tb_sdram_reader.sv - scoreboard bench for sdram_reader with an Avalon-MM slave model.
module tb_sdram_reader;

  localparam int unsigned RBUF = 20000;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [31:0] start_index = 32'd0;
  logic [15:0] word_count = 16'd0;
  logic        busy;
  logic        done;
  logic [31:0] address;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [63:0] readdata = 64'd0;
  logic        readdatavalid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef SDRAM_READER_ERR_EN
  logic        err;
`endif

  sdram_reader #(.RBUF_SIZE(RBUF), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .start_index(start_index), .word_count(word_count), .busy(busy), .done(done),
    .address(address), .read(read), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SDRAM_READER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_accept = 0;
  int done_count = 0;
  logic rnd_mode = 1'b0;
  logic [31:0] hi_word = 32'd0;
  logic fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'd0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          rq_due[$];
  logic [63:0] rq_data[$];

  logic prev_read = 1'b0, prev_wait = 1'b0, prev_busy = 1'b0, prev_rdv = 1'b0, prev_reset = 1'b1;
  logic [31:0] prev_addr = 32'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_fn(input logic [31:0] a);
    if (fixed_en) return fixed_val;
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave model, output scoreboard and handshake monitors all act at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_mode) begin
        out_ready   = ($urandom_range(0, 3) != 0);
        waitrequest = ($urandom_range(0, 3) == 0);
      end
      if (done) done_count++;
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) check("exp_data_size", 64'(exp_data.size()), 64'd1);
        else check("out_data", out_data, exp_data.pop_front());
      end
      if (prev_read && prev_wait && !reset) begin
        check("hold_read", read, 1'b1);
        check("hold_addr", address, prev_addr);
      end
      if (prev_rdv && prev_busy && !reset && !prev_reset)
        check("rdv_to_valid", out_valid, 1'b1);
      prev_read  = read;
      prev_wait  = waitrequest;
      prev_addr  = address;
      prev_busy  = busy;
      prev_reset = reset;
      readdatavalid = 1'b0;
      readdata      = 64'd0;
      if (rq_due.size() != 0 && rq_due[0] <= cyc) begin
        readdatavalid = 1'b1;
        readdata      = rq_data.pop_front();
        void'(rq_due.pop_front());
      end
      prev_rdv = readdatavalid;
      if (read && !waitrequest && !reset) begin
        n_accept++;
        rq_due.push_back(cyc + LAT);
        rq_data.push_back({hi_word, word_fn(address)});
        if (exp_addr.size() == 0) check("exp_addr_size", 64'(exp_addr.size()), 64'd1);
        else check("address", address, exp_addr.pop_front());
      end
    end
  end

  task automatic push_expect(input logic [31:0] b, input logic [31:0] s, input int cnt);
    logic [31:0] idx;
    logic [31:0] a;
    idx = s;
    for (int i = 0; i < cnt; i++) begin
      a = b + idx;
      exp_addr.push_back(a);
      exp_data.push_back(word_fn(a));
      idx = (idx >= RBUF) ? 32'd0 : idx + 32'd2;
    end
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input int cnt);
    push_expect(b, s, cnt);
    base_addr   = b;
    start_index = s;
    word_count  = 16'(cnt);
    start       = 1'b1;
    tick();
    start = 1'b0;
    if (cnt != 0) check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < maxc) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({tag, "_done_once"}, 64'(done_count - d0), 64'd1);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    check({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
  endtask

  initial begin
    int a0;
    int d0;
    int n;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", read, 1'b0);
    check("rst_address", address, 32'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Basic readback plus a start pulse while busy that must be ignored.
    start_xfer(32'h1000, 32'd10, 3);
    check("first_read", read, 1'b1);
    check("first_addr", address, 32'h100A);
    tick();
    base_addr   = 32'hDEAD0000;
    start_index = 32'd0;
    word_count  = 16'd7;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_done("basic", 200);

    start_xfer(32'h8000, 32'd19998, 3);
    wait_done("wrap", 200);

    // Zero-length readback.
    a0 = n_accept;
    d0 = done_count;
    start_xfer(32'h9000, 32'd0, 0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_done_drop", done, 1'b0);
    repeat (4) tick();
    check("zero_done_count", 64'(done_count - d0), 64'd1);
    check("zero_no_read", 64'(n_accept - a0), 64'd0);

    // Credit limit with a blocked consumer.
    out_ready = 1'b0;
    a0 = n_accept;
    start_xfer(32'h2000, 32'd0, 10);
    repeat (20) tick();
    check("credit_reads", 64'(n_accept - a0), 64'd4);
    check("credit_read_low", read, 1'b0);
    out_ready = 1'b1;
    wait_done("credit", 300);

    // Stall on the first read.
    waitrequest = 1'b1;
    a0 = n_accept;
    start_xfer(32'h3000, 32'd100, 4);
    repeat (5) tick();
    check("stall_no_accept", 64'(n_accept - a0), 64'd0);
    check("stall_addr", address, 32'h3064);
    check("stall_read", read, 1'b1);
    waitrequest = 1'b0;
    wait_done("stall", 200);

    // Random backpressure and stalls across an index wrap and a 32-bit address wrap.
    rnd_mode = 1'b1;
    start_xfer(32'hFFFF_FF00, 32'd19990, 30);
    wait_done("random", 3000);
    rnd_mode = 1'b0;
    tick();
    out_ready   = 1'b1;
    waitrequest = 1'b0;
    tick();

    // Reset in the middle of a transfer.
    a0 = n_accept;
    start_xfer(32'h5000, 32'd0, 5);
    n = 0;
    while (n_accept < a0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("mid_two_reads", 64'(n_accept - a0), 64'd2);
    waitrequest = 1'b1;
    reset       = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_read", read, 1'b0);
    check("mid_rst_address", address, 32'd0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) tick();
    reset       = 1'b0;
    waitrequest = 1'b0;
    d0 = done_count;
    a0 = n_accept;
    repeat (10) tick();
    check("mid_no_done", 64'(done_count - d0), 64'd0);
    check("mid_no_resume", 64'(n_accept - a0), 64'd0);
    check("mid_idle_busy", busy, 1'b0);
    check("mid_idle_valid", out_valid, 1'b0);

    start_xfer(32'h6000, 32'd4, 3);
    wait_done("recover", 200);

`ifdef SDRAM_READER_ERR_EN
    check("err_clean", err, 1'b0);
    hi_word   = 32'd1;
    fixed_en  = 1'b1;
    fixed_val = 32'd5;
    start_xfer(32'h7000, 32'd0, 1);
    wait_done("err", 200);
    check("err_set", err, 1'b1);
    repeat (3) tick();
    check("err_sticky", err, 1'b1);
    hi_word  = 32'd0;
    fixed_en = 1'b0;
    start_xfer(32'h7000, 32'd0, 1);
    check("err_clear", err, 1'b0);
    wait_done("err2", 200);
    check("err_stays_clear", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
